// File: rtl/claa_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
package claa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } grp_pg_t;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    function automatic int calc_ng(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/claa_group.sv
// One GROUP-bit lookahead slice: every carry is a flat generate/propagate product, never a ripple.
module claa_group
    import claa_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output grp_pg_t          pg,
    output logic             cout,
    output logic             c_msb_in
);

    logic [GROUP-1:0] g, p;
    logic [GROUP:0]   gen_c, prop_c, c;
    logic             acc, pp;

    assign g = a & b;
    assign p = a ^ b;

    // gen_c[i]: carry generated inside bits [i-1:0]; prop_c[i]: all of them propagate
    always_comb begin
        gen_c  = '0;
        prop_c = '0;
        acc    = 1'b0;
        pp     = 1'b1;
        for (int i = 0; i <= GROUP; i++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (g[j] & pp);
                pp  = pp & p[j];
            end
            gen_c[i]  = acc;
            prop_c[i] = pp;
        end
    end

    assign c        = gen_c | (prop_c & {(GROUP+1){cin}});
    assign sum      = p ^ c[GROUP-1:0];
    assign pg.g     = gen_c[GROUP];
    assign pg.p     = prop_c[GROUP];
    assign cout     = c[GROUP];
    assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/claa_pipe_addsub.sv
// Pipelined lookahead add/sub: one group per stage, operands skewed in, sum bits deskewed out.
module claa_pipe_addsub
    import claa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NG = calc_ng(WIDTH, GROUP);

    if (WIDTH % GROUP != 0) begin : g_bad_width
        $error("claa_pipe_addsub: WIDTH must be a multiple of GROUP");
    end

    logic                     adv;
    mode_e                    mode;
    logic [NG-1:0]            vld_pipe;
    logic [NG-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [NG-1:0]            c_q;
    logic                     ovf_q, zero_q;

    // stage sources (sa/sb/sc/ss) and merged stage results (ns)
    logic [NG-1:0][WIDTH-1:0] sa, sb, ss, ns;
    logic [NG-1:0]            sc;
    logic [NG-1:0][GROUP-1:0] gsum;
    grp_pg_t [NG-1:0]         gpg;
    logic [NG-1:0]            gco, gcm;

    assign mode     = in_sub ? MODE_SUB : MODE_ADD;
    assign adv      = !vld_pipe[NG-1] || out_ready;
    assign in_ready = adv;

    assign sa[0] = in_a;
    assign sb[0] = (mode == MODE_SUB) ? ~in_b : in_b;
    assign sc[0] = (mode == MODE_SUB) || in_cin;
    assign ss[0] = '0;

    for (genvar k = 0; k < NG; k++) begin : g_stage
        if (k > 0) begin : g_src
            assign sa[k] = a_q[k-1];
            assign sb[k] = b_q[k-1];
            assign sc[k] = c_q[k-1];
            assign ss[k] = s_q[k-1];
        end

        claa_group #(.GROUP(GROUP)) u_grp (
            .a        (sa[k][k*GROUP +: GROUP]),
            .b        (sb[k][k*GROUP +: GROUP]),
            .cin      (sc[k]),
            .sum      (gsum[k]),
            .pg       (gpg[k]),
            .cout     (gco[k]),
            .c_msb_in (gcm[k])
        );

        // deskewed sum is zero above the groups already resolved, so OR merges cleanly
        assign ns[k] = ss[k] | (WIDTH'(gsum[k]) << (k*GROUP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else if (adv) begin
            vld_pipe <= (vld_pipe << 1) | NG'(in_valid);
            for (int k = 0; k < NG; k++) begin
                a_q[k] <= sa[k];
                b_q[k] <= sb[k];
                s_q[k] <= ns[k];
                c_q[k] <= gpg[k].g | (gpg[k].p & sc[k]);
            end
            ovf_q  <= gcm[NG-1] ^ gco[NG-1];
            zero_q <= (ns[NG-1] == '0);
        end
    end

    assign out_valid = vld_pipe[NG-1];
    assign out_sum   = s_q[NG-1];
    assign out_cout  = c_q[NG-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_claa_pipe_addsub.sv
// Bench for claa_pipe_addsub: directed corner vectors, stall, reset flush and random traffic.
module tb_claa_pipe_addsub;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, in_cin, in_sub;
    logic [W-1:0] in_a, in_b;
    logic         out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [W-1:0] out_sum;

    claa_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic         kv;
        logic [W-1:0] ks;
        logic         kc, ko, kz;
    } stim_t;

    typedef struct {
        stim_t        s;
        logic [W-1:0] sum;
        logic         cout, ovf, zero;
        int           cyc;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    checks = 0, failures = 0, cyc = 0, popped = 0;
    bit    chk_lat = 0, stall_win = 0, drive_rand = 0;
    logic         held_v = 1'b0;
    logic [W-1:0] held_sum;
    logic [2:0]   held_flags;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // signed/unsigned integer arithmetic straight from the add/sub definition
    function automatic exp_t model(input stim_t s);
        exp_t   e;
        longint full, sr, sa, sb;
        sa = longint'($signed(s.a));
        sb = longint'($signed(s.b));
        if (s.sub) begin
            full = longint'(s.a) - longint'(s.b) + (longint'(1) << W);
            sr   = sa - sb;
        end else begin
            full = longint'(s.a) + longint'(s.b) + longint'(s.cin);
            sr   = sa + sb + longint'(s.cin);
        end
        e.s    = s;
        e.sum  = W'(full);
        e.cout = full[W];
        e.ovf  = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
        e.zero = (e.sum == '0);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic add_stim(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, input logic kv, input logic [W-1:0] ks,
                            input logic kc, input logic ko, input logic kz);
        stim_t s;
        s.a = a; s.b = b; s.cin = cin; s.sub = sub;
        s.kv = kv; s.ks = ks; s.kc = kc; s.ko = ko; s.kz = kz;
        stim_q.push_back(s);
    endtask

    task automatic add_rand(input int n);
        for (int i = 0; i < n; i++)
            add_stim(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // one clock: drive after the edge, observe and score at the falling edge
    task automatic tick();
        exp_t e;
        if (stim_q.size() > 0 && (!drive_rand || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_a = stim_q[0].a; in_b = stim_q[0].b;
            in_cin = stim_q[0].cin; in_sub = stim_q[0].sub;
        end else begin
            in_valid = 1'b0;
            in_a = W'($urandom); in_b = W'($urandom);
            in_cin = 1'($urandom); in_sub = 1'($urandom);
        end
        @(negedge clk);
        if (held_v) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_sum", out_sum, held_sum);
            chk("stall_flags", {out_cout, out_ovf, out_zero}, held_flags);
        end
        if (stall_win) chk("stall_in_ready", in_ready, 1'b0);
        if (out_valid && exp_q.size() == 0) chk("spurious_out", out_valid, 1'b0);
        if (in_valid && in_ready) begin
            e = model(stim_q.pop_front());
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        if (out_valid && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            chk("sum", out_sum, e.sum);
            chk("cout", out_cout, e.cout);
            chk("ovf", out_ovf, e.ovf);
            chk("zero", out_zero, e.zero);
            if (e.s.kv) chk("vector", {out_sum, out_cout, out_ovf, out_zero},
                            {e.s.ks, e.s.kc, e.s.ko, e.s.kz});
            if (chk_lat) chk("latency", cyc - e.cyc, NG);
        end
        held_v     = out_valid && !out_ready;
        held_sum   = out_sum;
        held_flags = {out_cout, out_ovf, out_zero};
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && (stim_q.size() > 0 || exp_q.size() > 0); i++) begin
            out_ready = 1'b1;
            tick();
        end
        chk(tag, stim_q.size() + exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;

        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, '0);
        chk("rst_flags", {out_cout, out_ovf, out_zero}, 3'b000);
        #10 rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // corner vectors, back to back, fixed latency
        chk_lat = 1;
        add_stim(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        add_stim(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        add_stim(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
        add_stim(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        add_stim(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        add_stim(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain("directed_drain", 200);
        chk_lat = 0;

        // 8 beats with a 4-cycle downstream stall once results are flowing
        p0 = popped;
        add_rand(8);
        for (int j = 0; j < 30; j++) begin
            out_ready = !(j >= 5 && j <= 8);
            stall_win = (j >= 5 && j <= 8);
            tick();
        end
        stall_win = 0;
        drain("stall_drain", 200);
        chk("stall_count", popped - p0, 8);

        // fill the pipe behind a stalled output, then reset mid-flight
        out_ready = 1'b0;
        add_rand(6);
        repeat (8) tick();
        chk("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_sum", out_sum, '0);
        stim_q.delete();
        exp_q.delete();
        held_v = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("post_rst_idle", out_valid, 1'b0);

        // random traffic with random backpressure
        p0 = popped;
        drive_rand = 1;
        add_rand(1000);
        for (int i = 0; i < 20000 && (stim_q.size() > 0 || exp_q.size() > 0); i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive_rand = 0;
        chk("random_drained", stim_q.size() + exp_q.size(), 0);
        chk("random_count", popped - p0, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
